// File: rtl/ldl_rr_req_cnt_if.sv
// Request/grant bundle between the event sources, the pending-event counter and the arbiter.
// The master side posts events and grants and observes the counters. The slave side is the counter block.
interface ldl_rr_req_cnt_if #(
  parameter int BIN_WIDTH = 3,
  parameter int CNT_WIDTH = 4,
  localparam int REQ_WIDTH = 1 << BIN_WIDTH,
  localparam int TOT_WIDTH = CNT_WIDTH + BIN_WIDTH
);
  logic [REQ_WIDTH-1:0]           inc;
  logic                           gnt_valid;
  logic                           gnt_ready;
  logic [BIN_WIDTH-1:0]           gnt_bin;
  logic                           clr_err;
  logic [REQ_WIDTH-1:0]           req;
  logic [REQ_WIDTH*CNT_WIDTH-1:0] cnt;
  logic [REQ_WIDTH-1:0]           full;
  logic [TOT_WIDTH-1:0]           total;
  logic                           empty;
  logic [REQ_WIDTH-1:0]           ovf;
  logic [REQ_WIDTH-1:0]           unf;

  modport master (
    output inc, gnt_valid, gnt_ready, gnt_bin, clr_err,
    input  req, cnt, full, total, empty, ovf, unf
  );

  modport slave (
    input  inc, gnt_valid, gnt_ready, gnt_bin, clr_err,
    output req, cnt, full, total, empty, ovf, unf
  );
endinterface

// File: rtl/ldl_rr_req_cnt.sv
// Per-requester pending-event counters that feed the round-robin arbiter's req vector.
// Each accepted grant retires one event. Counters saturate, and the sticky ovf/unf flags record any lost accounting.
module ldl_rr_req_cnt #(
  parameter int BIN_WIDTH = 3,
  parameter int CNT_WIDTH = 4,
  localparam int REQ_WIDTH = 1 << BIN_WIDTH,
  localparam int TOT_WIDTH = CNT_WIDTH + BIN_WIDTH
) (
  input logic             clk,
  input logic             rst,
  ldl_rr_req_cnt_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [REQ_WIDTH*CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [REQ_WIDTH-1:0]           ovf_q, ovf_d, ovf_set;
  logic [REQ_WIDTH-1:0]           unf_q, unf_d, unf_set;
  logic [TOT_WIDTH-1:0]           total_q, total_d;
  logic [REQ_WIDTH-1:0]           req_w, full_w;
  logic [CNT_WIDTH-1:0]           cur;
  logic                           gnt, dec_i;

  assign gnt = bus.gnt_valid & bus.gnt_ready;

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = '0;
    unf_set = '0;
    total_d = '0;
    cur     = '0;
    dec_i   = 1'b0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      cur   = cnt_q[i*CNT_WIDTH +: CNT_WIDTH];
      dec_i = gnt && (bus.gnt_bin == BIN_WIDTH'(i));
      case ({bus.inc[i], dec_i})
        2'b10: begin
          if (cur == CNT_MAX) ovf_set[i] = 1'b1;
          else cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = cur + CNT_WIDTH'(1);
        end
        2'b01: begin
          if (cur == '0) unf_set[i] = 1'b1;
          else cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = cur - CNT_WIDTH'(1);
        end
        // A grant against an empty counter is bogus, but the new event still counts.
        2'b11: begin
          if (cur == '0) begin
            cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(1);
            unf_set[i] = 1'b1;
          end
        end
        default: ;
      endcase
      total_d = total_d + TOT_WIDTH'(cnt_d[i*CNT_WIDTH +: CNT_WIDTH]);
    end
    ovf_d = ovf_set | (ovf_q & ~{REQ_WIDTH{bus.clr_err}});
    unf_d = unf_set | (unf_q & ~{REQ_WIDTH{bus.clr_err}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ovf_q   <= '0;
      unf_q   <= '0;
      total_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      total_q <= total_d;
    end
  end

  always_comb begin
    req_w  = '0;
    full_w = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      req_w[i]  = cnt_q[i*CNT_WIDTH +: CNT_WIDTH] != '0;
      full_w[i] = cnt_q[i*CNT_WIDTH +: CNT_WIDTH] == CNT_MAX;
    end
  end

  assign bus.req   = req_w;
  assign bus.full  = full_w;
  assign bus.cnt   = cnt_q;
  assign bus.total = total_q;
  assign bus.empty = ~|cnt_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: tb/tb_ldl_rr_req_cnt.sv
// Directed bench for ldl_rr_req_cnt: a table of per-cycle vectors with hand-computed counts, then multi-cycle sequences.
// The sequences cover saturation and a closed loop through a small round-robin arbiter model.
module tb_ldl_rr_req_cnt;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ldl_rr_req_cnt_if bus ();

  ldl_rr_req_cnt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  inc;
    logic        gv;
    logic        gr;
    logic [2:0]  bin;
    logic        clr;
    logic [31:0] ecnt;
    logic [7:0]  eovf;
    logic [7:0]  eunf;
    logic [6:0]  etot;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(input logic r, input logic [7:0] inc, input logic gv, input logic gr,
                              input logic [2:0] bin, input logic clr, input logic [31:0] ecnt,
                              input logic [7:0] eovf, input logic [7:0] eunf, input logic [6:0] etot);
    vec_t v;
    v.rst = r; v.inc = inc; v.gv = gv; v.gr = gr; v.bin = bin; v.clr = clr;
    v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf; v.etot = etot;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] req_of(input logic [31:0] c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (c[i*4 +: 4] != 4'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] inc, input logic gv, input logic gr,
                       input logic [2:0] bin, input logic clr);
    rst = r; bus.inc = inc; bus.gnt_valid = gv; bus.gnt_ready = gr; bus.gnt_bin = bin; bus.clr_err = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         ptr, pick, ngr;
  int         gbins[4];
  int         exp_bins[4] = '{0, 2, 5, 7};
  logic [7:0] rq;

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    // rst inc gv gr bin clr | cnt ovf unf total
    add(1, 8'hff, 0, 0, 0, 0, 32'h00000000, 8'h00, 8'h00, 7'd0);
    add(1, 8'hff, 0, 0, 0, 0, 32'h00000000, 8'h00, 8'h00, 7'd0);
    add(0, 8'hff, 0, 0, 0, 0, 32'h11111111, 8'h00, 8'h00, 7'd8);
    add(1, 8'h00, 0, 0, 0, 0, 32'h00000000, 8'h00, 8'h00, 7'd0);
    for (int k = 1; k <= 5; k++)
      add(0, 8'h04, 0, 0, 0, 0, 32'(k) << 8, 8'h00, 8'h00, 7'(k));
    for (int k = 4; k >= 0; k--)
      add(0, 8'h00, 1, 1, 2, 0, 32'(k) << 8, 8'h00, 8'h00, 7'(k));
    for (int k = 1; k <= 3; k++)
      add(0, 8'h20, 0, 0, 0, 0, 32'(k) << 20, 8'h00, 8'h00, 7'(k));
    add(0, 8'h20, 1, 1, 5, 0, 32'h00300000, 8'h00, 8'h00, 7'd3);
    add(0, 8'h20, 1, 0, 5, 0, 32'h00400000, 8'h00, 8'h00, 7'd4);
    add(0, 8'h00, 1, 0, 5, 0, 32'h00400000, 8'h00, 8'h00, 7'd4);
    add(0, 8'h00, 1, 1, 7, 0, 32'h00400000, 8'h00, 8'h80, 7'd4);
    add(0, 8'h00, 1, 1, 7, 1, 32'h00400000, 8'h00, 8'h80, 7'd4);
    add(0, 8'h00, 0, 0, 0, 1, 32'h00400000, 8'h00, 8'h00, 7'd4);
    add(0, 8'h80, 1, 1, 7, 0, 32'h10400000, 8'h00, 8'h80, 7'd5);
    add(0, 8'h00, 0, 0, 0, 1, 32'h10400000, 8'h00, 8'h00, 7'd5);
    add(0, 8'h01, 1, 1, 5, 0, 32'h10300001, 8'h00, 8'h00, 7'd5);
    add(1, 8'hff, 1, 1, 0, 0, 32'h00000000, 8'h00, 8'h00, 7'd0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].inc, vecs[k].gv, vecs[k].gr, vecs[k].bin, vecs[k].clr);
      step();
      chk($sformatf("v%0d cnt", k), bus.cnt, vecs[k].ecnt);
      chk($sformatf("v%0d ovf", k), 32'(bus.ovf), 32'(vecs[k].eovf));
      chk($sformatf("v%0d unf", k), 32'(bus.unf), 32'(vecs[k].eunf));
      chk($sformatf("v%0d total", k), 32'(bus.total), 32'(vecs[k].etot));
      chk($sformatf("v%0d req", k), 32'(bus.req), 32'(req_of(vecs[k].ecnt)));
      chk($sformatf("v%0d empty", k), 32'(bus.empty), 32'(vecs[k].ecnt == 32'd0));
    end

    // saturation on requester 0
    drive(1, 8'h00, 0, 0, 0, 0); step();
    for (int p = 1; p <= 17; p++) begin
      drive(0, 8'h01, 0, 0, 0, 0);
      step();
      chk($sformatf("sat%0d cnt0", p), 32'(bus.cnt[3:0]), (p >= 15) ? 32'd15 : 32'(p));
      chk($sformatf("sat%0d full0", p), 32'(bus.full[0]), 32'(p >= 15));
      chk($sformatf("sat%0d ovf", p), 32'(bus.ovf), (p >= 16) ? 32'h1 : 32'h0);
    end
    drive(0, 8'h01, 1, 1, 0, 0); step();
    chk("sat net-zero cnt0", 32'(bus.cnt[3:0]), 32'd15);
    chk("sat net-zero unf", 32'(bus.unf), 32'h0);
    chk("sat net-zero ovf", 32'(bus.ovf), 32'h1);
    drive(0, 8'h01, 0, 0, 0, 1); step();
    chk("sat set-beats-clr ovf", 32'(bus.ovf), 32'h1);
    drive(0, 8'h00, 0, 0, 0, 1); step();
    chk("sat clr ovf", 32'(bus.ovf), 32'h0);
    chk("sat total", 32'(bus.total), 32'd15);

    // closed loop through a round-robin arbiter model
    drive(1, 8'h00, 0, 0, 0, 0); step();
    drive(0, 8'ha5, 0, 0, 0, 0); step();
    drive(0, 8'h00, 0, 0, 0, 0);
    ptr = 0; ngr = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      rq = bus.req;
      if (rq == 8'h00) break;
      pick = -1;
      for (int k = 0; k < 8; k++)
        if (pick < 0 && rq[(ptr + k) % 8]) pick = (ptr + k) % 8;
      if (ngr < 4) gbins[ngr] = pick;
      ngr++;
      ptr = (pick + 1) % 8;
      drive(0, 8'h00, 1, 1, 3'(pick), 0);
      step();
      drive(0, 8'h00, 0, 0, 0, 0);
    end
    chk("arb grant count", 32'(ngr), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < ngr) chk($sformatf("arb grant%0d bin", k), 32'(gbins[k]), 32'(exp_bins[k]));
    chk("arb req", 32'(bus.req), 32'h0);
    chk("arb empty", 32'(bus.empty), 32'h1);
    chk("arb total", 32'(bus.total), 32'd0);
    chk("arb unf", 32'(bus.unf), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
